// File: rtl/sobel_pkg.sv
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared definitions for the Sobel edge pixel pipeline.
//                Holds the output-mode encodings, the default widths, and
//                helpers that derive datapath widths from the channel width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

   localparam int DEF_CW  = 8;   // bits per colour channel
   localparam int DEF_SBW = 2;   // sideband width

   typedef enum logic [1:0] {
      MODE_MAG = 2'd0,   // L1 gradient magnitude
      MODE_THR = 2'd1,   // binary threshold on the magnitude
      MODE_GX  = 2'd2,   // |gx| only
      MODE_GY  = 2'd3    // |gy| only
   } mode_e;

   // Packed {R,G,B} pixel word.
   function automatic int pix_w(input int cw);
      return 3 * cw;
   endfunction

   // |gx| and |gy|: at most 4 * (2^cw - 1).
   function automatic int abs_w(input int cw);
      return cw + 2;
   endfunction

   // Signed gx/gy and the unsigned L1 sum: at most 8 * (2^cw - 1).
   function automatic int mag_w(input int cw);
      return cw + 3;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_edge_px_if.sv
// ============================================================================
//  Module      : sobel_edge_px_if
//  Description : Window-in / pixel-out stream bundle for sobel_edge_px.
//                slave  : the filter side (consumes the window, drives Dout)
//                master : the producer/consumer side surrounding the filter
//  Ports       : D00IN..D22IN, in_valid, in_ready, in_user, mode, thr,
//                Dout, out_valid, out_ready, out_user
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sobel_edge_px_if
   import sobel_pkg::*;
#(
   parameter int CW  = DEF_CW,
   parameter int SBW = DEF_SBW
) ();

   localparam int PW = pix_w(CW);

   // 3x3 window, Drc = row r (0 = top), column c (0 = left)
   logic [PW-1:0]  D00IN, D01IN, D02IN;
   logic [PW-1:0]  D10IN, D11IN, D12IN;
   logic [PW-1:0]  D20IN, D21IN, D22IN;
   logic           in_valid;
   logic           in_ready;
   logic [SBW-1:0] in_user;
   logic [1:0]     mode;
   logic [CW-1:0]  thr;

   logic [PW-1:0]  Dout;
   logic           out_valid;
   logic           out_ready;
   logic [SBW-1:0] out_user;

   modport slave (
      input  D00IN, D01IN, D02IN, D10IN, D11IN, D12IN, D20IN, D21IN, D22IN,
      input  in_valid, in_user, mode, thr, out_ready,
      output in_ready, Dout, out_valid, out_user
   );

   modport master (
      output D00IN, D01IN, D02IN, D10IN, D11IN, D12IN, D20IN, D21IN, D22IN,
      output in_valid, in_user, mode, thr, out_ready,
      input  in_ready, Dout, out_valid, out_user
   );

endinterface

`default_nettype wire

// File: rtl/sobel_gray.sv
// ============================================================================
//  Module      : sobel_gray
//  Description : Combinational {R,G,B} to gray conversion,
//                gray = (R + 2G + B) >> 2, summed at CW+2 bits so nothing
//                overflows before the shift.
//  Ports       : i_pix  - {R,G,B} pixel, R in the MSBs
//                o_gray - CW-bit gray value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_gray
   import sobel_pkg::*;
#(
   parameter int CW = DEF_CW
) (
   input  logic [pix_w(CW)-1:0] i_pix,
   output logic [CW-1:0]        o_gray
);

   logic [CW+1:0] sum;

   assign sum    = {2'b00, i_pix[3*CW-1:2*CW]}
                 + {1'b0,  i_pix[2*CW-1:CW], 1'b0}
                 + {2'b00, i_pix[CW-1:0]};
   assign o_gray = CW'(sum >> 2);

endmodule

`default_nettype wire

// File: rtl/sobel_edge_px.sv
// ============================================================================
//  Module      : sobel_edge_px
//  Description : 4-stage Sobel edge filter on a 3x3 RGB window.
//                S1 gray per tap, S2 signed gx/gy, S3 |gx|,|gy| and L1 sum,
//                S4 mode select + saturation to a gray RGB pixel.
//                Whole pipeline freezes while the output is stalled.
//  Ports       : CLK, RESET (async, active-high), bus (sobel_edge_px_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_edge_px
   import sobel_pkg::*;
#(
   parameter int CW  = DEF_CW,
   parameter int SBW = DEF_SBW
) (
   input  logic                  CLK,
   input  logic                  RESET,
   sobel_edge_px_if.slave        bus
);

   localparam int PW = pix_w(CW);
   localparam int AW = abs_w(CW);
   localparam int MW = mag_w(CW);
   localparam logic [MW-1:0] SAT_MAX = {{(MW-CW){1'b0}}, {CW{1'b1}}};

   // ---------------- stage registers ----------------
   logic                 s1_valid_q, s1_valid_d;
   logic [CW-1:0]        s1_gray_q [9];
   logic [CW-1:0]        s1_gray_d [9];
   logic [SBW-1:0]       s1_user_q, s1_user_d;
   mode_e                s1_mode_q, s1_mode_d;
   logic [CW-1:0]        s1_thr_q,  s1_thr_d;

   logic                 s2_valid_q, s2_valid_d;
   logic signed [MW-1:0] s2_gx_q, s2_gx_d, s2_gy_q, s2_gy_d;
   logic [SBW-1:0]       s2_user_q, s2_user_d;
   mode_e                s2_mode_q, s2_mode_d;
   logic [CW-1:0]        s2_thr_q,  s2_thr_d;

   logic                 s3_valid_q, s3_valid_d;
   logic [AW-1:0]        s3_ax_q, s3_ax_d, s3_ay_q, s3_ay_d;
   logic [MW-1:0]        s3_mag_q, s3_mag_d;
   logic [SBW-1:0]       s3_user_q, s3_user_d;
   mode_e                s3_mode_q, s3_mode_d;
   logic [CW-1:0]        s3_thr_q,  s3_thr_d;

   logic                 out_valid_q, out_valid_d;
   logic [PW-1:0]        dout_q, dout_d;
   logic [SBW-1:0]       out_user_q, out_user_d;

   // ---------------- handshake ----------------
   logic stall;
   assign stall        = out_valid_q & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.Dout      = dout_q;
   assign bus.out_user  = out_user_q;

   // ---------------- S1 gray converters ----------------
   // tap index = row*3 + col
   logic [PW-1:0] tap       [9];
   logic [CW-1:0] gray_tap  [9];

   assign tap[0] = bus.D00IN;  assign tap[1] = bus.D01IN;  assign tap[2] = bus.D02IN;
   assign tap[3] = bus.D10IN;  assign tap[4] = bus.D11IN;  assign tap[5] = bus.D12IN;
   assign tap[6] = bus.D20IN;  assign tap[7] = bus.D21IN;  assign tap[8] = bus.D22IN;

   generate
      for (genvar i = 0; i < 9; i++) begin : g_gray
         sobel_gray #(.CW(CW)) u_gray (
            .i_pix  (tap[i]),
            .o_gray (gray_tap[i])
         );
      end
   endgenerate

   // ---------------- S2 kernel partial sums ----------------
   // Each weighted half-sum is at most 4*(2^CW-1), so AW bits suffice;
   // the difference is formed in MW signed bits.
   logic [AW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

   assign gx_pos = AW'(s1_gray_q[0]) + AW'({s1_gray_q[3], 1'b0}) + AW'(s1_gray_q[6]);
   assign gx_neg = AW'(s1_gray_q[2]) + AW'({s1_gray_q[5], 1'b0}) + AW'(s1_gray_q[8]);
   assign gy_pos = AW'(s1_gray_q[6]) + AW'({s1_gray_q[7], 1'b0}) + AW'(s1_gray_q[8]);
   assign gy_neg = AW'(s1_gray_q[0]) + AW'({s1_gray_q[1], 1'b0}) + AW'(s1_gray_q[2]);

   // ---------------- S4 mode select / saturation ----------------
   logic [MW-1:0] v_full;
   logic [CW-1:0] v_sat;

   always_comb begin
      v_full = '0;
      case (s3_mode_q)
         MODE_MAG: v_full = s3_mag_q;
         MODE_THR: v_full = (s3_mag_q >= MW'(s3_thr_q)) ? SAT_MAX : '0;
         MODE_GX:  v_full = MW'(s3_ax_q);
         default:  v_full = MW'(s3_ay_q);
      endcase
      v_sat = (v_full > SAT_MAX) ? {CW{1'b1}} : v_full[CW-1:0];
   end

   // ---------------- next-state ----------------
   always_comb begin
      s1_valid_d  = s1_valid_q;   s1_gray_d = s1_gray_q;   s1_user_d = s1_user_q;
      s1_mode_d   = s1_mode_q;    s1_thr_d  = s1_thr_q;
      s2_valid_d  = s2_valid_q;   s2_gx_d   = s2_gx_q;     s2_gy_d   = s2_gy_q;
      s2_user_d   = s2_user_q;    s2_mode_d = s2_mode_q;   s2_thr_d  = s2_thr_q;
      s3_valid_d  = s3_valid_q;   s3_ax_d   = s3_ax_q;     s3_ay_d   = s3_ay_q;
      s3_mag_d    = s3_mag_q;     s3_user_d = s3_user_q;
      s3_mode_d   = s3_mode_q;    s3_thr_d  = s3_thr_q;
      out_valid_d = out_valid_q;  dout_d    = dout_q;      out_user_d = out_user_q;

      if (!stall) begin
         // S1: a bubble loads with valid=0; its data is don't-care
         s1_valid_d = bus.in_valid;
         s1_gray_d  = gray_tap;
         s1_user_d  = bus.in_user;
         s1_mode_d  = mode_e'(bus.mode);
         s1_thr_d   = bus.thr;
         // S2
         s2_valid_d = s1_valid_q;
         s2_gx_d    = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
         s2_gy_d    = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
         s2_user_d  = s1_user_q;
         s2_mode_d  = s1_mode_q;
         s2_thr_d   = s1_thr_q;
         // S3: |-4*(2^CW-1)| still fits AW bits, so truncating the negation is safe
         s3_valid_d = s2_valid_q;
         s3_ax_d    = s2_gx_q[MW-1] ? AW'(-s2_gx_q) : AW'(s2_gx_q);
         s3_ay_d    = s2_gy_q[MW-1] ? AW'(-s2_gy_q) : AW'(s2_gy_q);
         s3_mag_d   = MW'(s3_ax_d) + MW'(s3_ay_d);
         s3_user_d  = s2_user_q;
         s3_mode_d  = s2_mode_q;
         s3_thr_d   = s2_thr_q;
         // S4
         out_valid_d = s3_valid_q;
         dout_d      = {3{v_sat}};
         out_user_d  = s3_user_q;
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_valid_q  <= 1'b0;  s1_gray_q <= '{default: '0};  s1_user_q <= '0;
         s1_mode_q   <= MODE_MAG;  s1_thr_q <= '0;
         s2_valid_q  <= 1'b0;  s2_gx_q <= '0;  s2_gy_q <= '0;  s2_user_q <= '0;
         s2_mode_q   <= MODE_MAG;  s2_thr_q <= '0;
         s3_valid_q  <= 1'b0;  s3_ax_q <= '0;  s3_ay_q <= '0;  s3_mag_q <= '0;
         s3_user_q   <= '0;  s3_mode_q <= MODE_MAG;  s3_thr_q <= '0;
         out_valid_q <= 1'b0;  dout_q <= '0;  out_user_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;  s1_gray_q <= s1_gray_d;  s1_user_q <= s1_user_d;
         s1_mode_q   <= s1_mode_d;   s1_thr_q  <= s1_thr_d;
         s2_valid_q  <= s2_valid_d;  s2_gx_q <= s2_gx_d;  s2_gy_q <= s2_gy_d;
         s2_user_q   <= s2_user_d;   s2_mode_q <= s2_mode_d;  s2_thr_q <= s2_thr_d;
         s3_valid_q  <= s3_valid_d;  s3_ax_q <= s3_ax_d;  s3_ay_q <= s3_ay_d;
         s3_mag_q    <= s3_mag_d;    s3_user_q <= s3_user_d;
         s3_mode_q   <= s3_mode_d;   s3_thr_q  <= s3_thr_d;
         out_valid_q <= out_valid_d; dout_q <= dout_d;  out_user_q <= out_user_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sobel_edge_px.sv
// ============================================================================
//  Module      : tb_sobel_edge_px
//  Description : Scoreboard bench for sobel_edge_px. Directed windows with
//                hand-computed results are queued on acceptance; a monitor
//                pops and compares whenever an output is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_edge_px;
   import sobel_pkg::*;

   localparam int CW  = 8;
   localparam int SBW = 2;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   sobel_edge_px_if #(.CW(CW), .SBW(SBW)) bus ();

   sobel_edge_px #(.CW(CW), .SBW(SBW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [23:0] dout;
      logic [1:0]  user;
      int          p_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [23:0] tap [9];

   assign bus.D00IN = tap[0];  assign bus.D01IN = tap[1];  assign bus.D02IN = tap[2];
   assign bus.D10IN = tap[3];  assign bus.D11IN = tap[4];  assign bus.D12IN = tap[5];
   assign bus.D20IN = tap[6];  assign bus.D21IN = tap[7];  assign bus.D22IN = tap[8];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic set_all(input logic [23:0] x);
      for (int i = 0; i < 9; i++) tap[i] = x;
   endtask

   task automatic set_cols(input logic [23:0] l, input logic [23:0] m, input logic [23:0] r);
      for (int i = 0; i < 3; i++) begin
         tap[i*3+0] = l;  tap[i*3+1] = m;  tap[i*3+2] = r;
      end
   endtask

   task automatic set_rows(input logic [23:0] t, input logic [23:0] m, input logic [23:0] b);
      for (int i = 0; i < 3; i++) begin
         tap[i] = t;  tap[3+i] = m;  tap[6+i] = b;
      end
   endtask

   // Present the current taps until accepted; queue the expected gray pixel v.
   task automatic send(input logic [1:0] m, input logic [7:0] t, input logic [1:0] u,
                       input logic [7:0] v, input bit lat);
      int p;
      bit acc;
      acc = 1'b0;
      p   = cyc;
      bus.mode = m;  bus.thr = t;  bus.in_user = u;  bus.in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         p = cyc;
         @(negedge CLK);
         acc = bus.in_ready;
         @(posedge CLK);
         #1;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready never 1, required accept within 50 cycles");
      end else begin
         sb.push_back('{dout: {3{v}}, user: u, p_cyc: p, chk_lat: lat});
      end
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 100 && sb.size() != 0; k++) begin
         @(posedge CLK);
         #1;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: got out_valid=1 Dout=%h, required no output", bus.Dout);
               end else begin
                  chk("dout", bus.Dout, sb[0].dout);
                  chk("out_user", bus.out_user, sb[0].user);
                  if (bus.out_ready) begin
                     if (sb[0].chk_lat) chk("latency", cyc, sb[0].p_cyc + 4);
                     void'(sb.pop_front());
                  end
               end
            end
            chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      set_all(24'h0);
      bus.in_valid  = 1'b0;
      bus.in_user   = '0;
      bus.mode      = 2'd0;
      bus.thr       = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_dout",      bus.Dout, 0);
      chk("rst_out_user",  bus.out_user, 0);
      chk("rst_in_ready",  bus.in_ready, 1);
      RESET = 1'b0;
      idle(2);

      // flat field
      set_all(24'h808080);
      send(2'd0, 8'd0, 2'd1, 8'h00, 1);
      idle(6);

      // vertical edge: gx = 1020 saturates; |gy| = 0
      set_cols(24'hFFFFFF, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd2, 8'hFF, 1);
      send(2'd3, 8'd0, 2'd3, 8'h00, 1);
      idle(6);

      // gradient of 10: mag = 40
      set_cols(24'h0A0A0A, 24'h0, 24'h0);
      send(2'd0, 8'd0,  2'd0, 8'h28, 1);
      send(2'd1, 8'd40, 2'd1, 8'hFF, 1);
      send(2'd1, 8'd41, 2'd2, 8'h00, 1);
      // negative gx from a right-hand column
      set_cols(24'h0, 24'h0, 24'h0A0A0A);
      send(2'd2, 8'd0, 2'd3, 8'h28, 1);
      set_cols(24'h0, 24'h0, 24'hFFFFFF);
      send(2'd2, 8'd0, 2'd0, 8'hFF, 1);
      // channel weights: R and B count once, G twice
      set_cols(24'h400000, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd1, 8'h40, 1);
      set_cols(24'h004000, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd2, 8'h80, 1);
      set_cols(24'h000040, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd3, 8'h40, 1);
      // saturation boundary: 252 passes, 256 clips
      set_cols(24'h3F3F3F, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd0, 8'hFC, 1);
      set_cols(24'h404040, 24'h0, 24'h0);
      send(2'd0, 8'd0, 2'd1, 8'hFF, 1);
      // corner taps: gx and gy both 16 in magnitude
      set_all(24'h0);
      tap[0] = 24'h101010;
      send(2'd0, 8'd0, 2'd2, 8'h20, 1);
      send(2'd2, 8'd0, 2'd3, 8'h10, 1);
      send(2'd3, 8'd0, 2'd0, 8'h10, 1);
      set_all(24'h0);
      tap[8] = 24'h101010;
      send(2'd0, 8'd0, 2'd1, 8'h20, 1);
      drain();

      // mode switch on horizontal edges: mag = |gy| = 4k, |gx| = 0
      for (int k = 1; k <= 6; k++) begin
         set_rows({3{8'(k)}}, 24'h0, 24'h0);
         if (k % 2 == 1) send(2'd0, 8'd0, 2'(k), 8'(4*k), 1);
         else            send(2'd2, 8'd0, 2'(k), 8'h00, 1);
      end
      set_rows(24'h050505, 24'h0, 24'h0);
      send(2'd3, 8'd0, 2'd3, 8'h14, 1);
      drain();

      // backpressure: 8 windows, out_ready low for 3 cycles mid-stream
      fork
         begin
            for (int k = 1; k <= 8; k++) begin
               set_cols({3{8'(k)}}, 24'h0, 24'h0);
               send(2'd0, 8'd0, 2'(k), 8'(4*k), 0);
            end
            bus.in_valid = 1'b0;
         end
         begin
            repeat (6) begin
               @(posedge CLK);
               #1;
            end
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge CLK);
               chk("bp_in_ready",  bus.in_ready, 0);
               chk("bp_out_valid", bus.out_valid, 1);
               @(posedge CLK);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // reset with windows in flight and one at the output
      for (int k = 9; k <= 12; k++) begin
         set_rows({3{8'(k)}}, 24'h0, 24'h0);
         send(2'd0, 8'd0, 2'(k), 8'(4*k), 1);
      end
      bus.in_valid = 1'b0;
      RESET = 1'b1;
      sb.delete();
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_dout",      bus.Dout, 0);
      chk("midrst_in_ready",  bus.in_ready, 1);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      idle(8);
      set_rows(24'h0D0D0D, 24'h0, 24'h0);
      send(2'd3, 8'd0, 2'd2, 8'h34, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sobel_edge_px.md
SOBEL_EDGE_PX -- requirements
Module: sobel_edge_px

Interface
REQ-001 Parameter CW, default 8, bits per colour channel; pixel word is 3*CW bits, {R,G,B}, R in the MSBs.
REQ-002 Parameter SBW, default 2, width of the user sideband (e.g. SOF, EOL) that travels aligned with each pixel.
REQ-003 Port CLK  in  1  sole clock; all state on rising edge.
REQ-004 Port RESET  in  1  reset, asynchronous assert, active-high.
REQ-005 Port D00IN..D22IN  in  3*CW each  3x3 window; Drc = row r (0 = top), column c (0 = left).
REQ-006 Port in_valid  in  1  window valid.
REQ-007 Port in_ready  out  1  block can accept the window this cycle.
REQ-008 Port in_user  in  SBW  sideband for the window.
REQ-009 Port mode  in  2  output mode, sampled with the window.
REQ-010 Port thr  in  CW  binary threshold, sampled with the window.
REQ-011 Port Dout  out  3*CW  result pixel.
REQ-012 Port out_valid  out  1  Dout valid.
REQ-013 Port out_ready  in  1  downstream accepts Dout.
REQ-014 Port out_user  out  SBW  sideband aligned with Dout.

Function
REQ-015 A window is accepted when in_valid and in_ready are both 1; Dout/out_valid is consumed when out_valid and out_ready are both 1.
REQ-016 stall = out_valid AND NOT out_ready; in_ready = NOT stall (combinational); while stall=1 every pipeline register, including out_user, holds its value.
REQ-017 Pipeline has 4 register stages: S1 gray, S2 gx/gy, S3 absolute values plus L1 sum, S4 mode select and saturation; an accepted window appears at the outputs 4 advancing cycles later.
REQ-018 Each stage carries a valid bit; bubbles (in_valid=0) propagate as valid=0 and never produce out_valid=1.
REQ-019 S1 computes gray = (R + 2G + B) >> 2 per tap, result CW bits, with no intermediate overflow (CW+2-bit sum).
REQ-020 S2 computes signed CW+3-bit values: gx = (g00 + 2*g10 + g20) - (g02 + 2*g12 + g22); gy = (g20 + 2*g21 + g22) - (g00 + 2*g01 + g02).
REQ-021 S3 computes ax = |gx| and ay = |gy| (CW+2 bits each) and mag = ax + ay (CW+3 bits); it never overflows.
REQ-022 S4 saturates v to min(v, 2^CW - 1) and outputs Dout = {v,v,v}.
REQ-023 mode 0: v = mag (L1 magnitude).
REQ-024 mode 1: v = all-ones if mag >= thr, else 0.
REQ-025 mode 2: v = ax.
REQ-026 mode 3: v = ay.
REQ-027 mode and thr travel through the pipeline with their window, so a mode change affects only windows accepted after it.
REQ-028 The block has no dependence between windows; back-to-back accepts sustain one result per cycle while out_ready=1.

Reset
REQ-029 While RESET=1, all stage valid bits, out_valid, Dout, out_user and every datapath register are 0 and in_ready=1.
REQ-030 An assertion of RESET in the middle of a stream discards all in-flight windows; the first out_valid after release comes only from a window accepted after release.

Structure
REQ-031 A shared package sobel_pkg holds the mode encodings (MODE_MAG, MODE_THR, MODE_GX, MODE_GY) and the width constants derived from CW.
REQ-032 One sub-module, sobel_gray (one {R,G,B} word to CW-bit gray, combinational), is instantiated 9 times inside S1.

Verification
REQ-033 Flat field: all taps 0x808080, mode 0 -> Dout 0x000000, 4 cycles after accept.
REQ-034 Vertical edge: left column 0xFFFFFF, other taps 0, mode 0 -> gx=1020, gy=0, Dout 0xFFFFFF (saturated); mode 3 -> 0x000000.
REQ-035 Gradient: left column 0x0A0A0A, other taps 0 -> mode 0 Dout 0x282828; mode 1 with thr=40 -> 0xFFFFFF; mode 1 with thr=41 -> 0x000000.
REQ-036 Backpressure: stream 8 distinct windows and drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, Dout/out_user held stable, all 8 results delivered in order with no loss or duplication.
REQ-037 Mode switch: alternate mode 0/2 on consecutive windows -> each output matches the mode sampled with its own window.
REQ-038 Reset mid-stream: assert RESET for 1 cycle with 3 windows in flight -> out_valid=0 immediately; no stale output after release.
